// File: rtl/uart_tx_fifo.sv
// UART transmitter with a DEPTH-entry byte FIFO; first START bit one clock after a push into an empty FIFO.
// Writes while full are dropped and flagged on tx_overflow; define UART_TX_BREAK_EN to add the tx_break input.
module uart_tx_fifo #(
    parameter int BAUD_DIV  = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_start,
    input  logic [7:0]             data_in,
`ifdef UART_TX_BREAK_EN
    input  logic                   tx_break,
`endif
    output logic                   tx,
    output logic                   tx_busy,
    output logic                   tx_full,
    output logic                   tx_overflow,
    output logic                   tx_done,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX   = CW'(BAUD_DIV - 1);
    localparam logic [AW:0]     FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [2:0]      LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [7:0]      DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic            ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_dat;
    logic          par_bit;
    logic          push;
    logic          pop;
    logic          stop_end;
    logic          idle_go;
    logic          stop_go;

    // The full check uses the pre-pop count, so a same-cycle pop never frees a slot for the write.
    assign push     = tx_start && (fifo_count != FULL_CNT);
    assign stop_end = (state == S_STOP) && (cnt == CNT_MAX) && (bit_idx == LAST_STOP);
    assign tx_full  = (fifo_count == FULL_CNT);

`ifdef UART_TX_BREAK_EN
    logic brk_on;
    logic guard_on;

    assign idle_go = (state == S_IDLE) && !tx_break && !brk_on && !(guard_on && (cnt != CNT_MAX));
    assign stop_go = stop_end && !tx_break;
    assign tx_busy = (state != S_IDLE) || (fifo_count != '0) || brk_on || guard_on;
`else
    assign idle_go = (state == S_IDLE);
    assign stop_go = stop_end;
    assign tx_busy = (state != S_IDLE) || (fifo_count != '0);
`endif

    assign pop = (idle_go || stop_go) && (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            tx_overflow <= 1'b0;
        end else begin
            tx_overflow <= tx_start && (fifo_count == FULL_CNT);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_dat <= '0;
            par_bit   <= 1'b0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_on    <= 1'b0;
            guard_on  <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                // Head loads straight into START, also from the last stop clock, so frames abut.
                state     <= S_START;
                cnt       <= '0;
                bit_idx   <= '0;
                tx        <= 1'b0;
                shift_dat <= mem[rd_ptr];
                par_bit   <= (^(mem[rd_ptr] & DATA_MASK)) ^ ODD_PAR;
`ifdef UART_TX_BREAK_EN
                guard_on  <= 1'b0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                        if (tx_break) begin
                            tx       <= 1'b0;
                            brk_on   <= 1'b1;
                            guard_on <= 1'b0;
                            cnt      <= '0;
                        end else if (brk_on) begin
                            tx       <= 1'b1;
                            brk_on   <= 1'b0;
                            guard_on <= 1'b1;
                            cnt      <= '0;
                        end else if (guard_on && (cnt != CNT_MAX)) begin
                            tx  <= 1'b1;
                            cnt <= cnt + 1'b1;
                        end else begin
                            tx       <= 1'b1;
                            guard_on <= 1'b0;
                            cnt      <= '0;
                        end
`else
                        tx <= 1'b1;
`endif
                    end
                    S_START: begin
                        if (cnt == CNT_MAX) begin
                            state   <= S_DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                            tx      <= shift_dat[0];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (cnt == CNT_MAX) begin
                            cnt <= '0;
                            if (bit_idx == LAST_DATA) begin
                                bit_idx <= '0;
                                if (PARITY != 0) begin
                                    state <= S_PARITY;
                                    tx    <= par_bit;
                                end else begin
                                    state <= S_STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                tx      <= shift_dat[bit_idx + 3'd1];
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (cnt == CNT_MAX) begin
                            state   <= S_STOP;
                            cnt     <= '0;
                            bit_idx <= '0;
                            tx      <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (cnt == CNT_MAX) begin
                            cnt <= '0;
                            if (bit_idx == LAST_STOP) begin
                                state   <= S_IDLE;
                                bit_idx <= '0;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt     <= cnt + 1'b1;
                            tx_done <= (cnt == CNT_MAX - 1'b1) && (bit_idx == LAST_STOP);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
